// File: rtl/aes_stream_packer_if.sv
// Bundle-load, stream-beat and forward-bundle signals of the AES stream packer.
// master = surrounding logic that feeds and drains the packer; slave = the packer.
interface aes_stream_packer_if #(
  parameter int NUM_KEYS = 8,
  parameter int BEAT_W   = 64
);
  // Handshakes: a transfer happens on a rising clk edge where valid && ready are both 1.
  // The sender holds data stable and keeps valid high until that edge. ld_ready depends
  // only on internal state. fwd_rdy is a one-cycle strobe with no ready.
  logic                              bypass_en;
  logic                              ld_valid;
  logic                              ld_ready;
  logic [127:0]                      ld_state;
  logic [128*NUM_KEYS-1:0]           ld_keys;
  logic                              prod_valid;
  logic                              prod_ready;
  logic [BEAT_W-1:0]                 prod_data;
  logic [128*(NUM_KEYS+1)-1:0]       fwd_data;
  logic                              fwd_rdy;
  logic                              busy;

  modport master (
    output bypass_en, ld_valid, ld_state, ld_keys, prod_ready,
    input  ld_ready, prod_valid, prod_data, fwd_data, fwd_rdy, busy
  );

  modport slave (
    input  bypass_en, ld_valid, ld_state, ld_keys, prod_ready,
    output ld_ready, prod_valid, prod_data, fwd_data, fwd_rdy, busy
  );
endinterface

// File: rtl/aes_stream_packer.sv
// Captures an AES state plus NUM_KEYS round keys. It then either streams them as
// 64-bit beats (high half of each block first) or presents them once on the forward port.
module aes_stream_packer #(
  parameter int NUM_KEYS = 8,
  parameter int BEAT_W   = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  aes_stream_packer_if.slave  bus,
  output logic [1:0]          dbg_state,
  output logic                dbg_bypass
);

  localparam int NB = NUM_KEYS + 1;
  localparam int N  = 2 * NB;
  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FWD    = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [128*NB-1:0] blk_q;
  logic              byp_q;
  logic              load;
  logic [BEAT_W-1:0] beat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      blk_q   <= '0;
      byp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load) begin
        blk_q <= {bus.ld_keys, bus.ld_state};
        byp_q <= bus.bypass_en;
      end
    end
  end

  // Even beats carry bits [127:64] of a block, odd beats carry bits [63:0].
  always_comb begin
    beat = '0;
    for (int b = 0; b < N; b++) begin
      if (cnt_q == CW'(b)) begin
        if ((b % 2) != 0) beat = blk_q[128*(b/2) +: BEAT_W];
        else              beat = blk_q[128*(b/2)+BEAT_W +: BEAT_W];
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    load           = 1'b0;
    bus.ld_ready   = 1'b0;
    bus.prod_valid = 1'b0;
    bus.prod_data  = '0;
    bus.fwd_rdy    = 1'b0;
    case (state_q)
      IDLE: begin
        bus.ld_ready = 1'b1;
        if (bus.ld_valid) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = bus.bypass_en ? FWD : STREAM;
        end
      end
      STREAM: begin
        bus.prod_valid = 1'b1;
        bus.prod_data  = beat;
        if (bus.prod_ready) begin
          if (cnt_q == CW'(N-1)) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      FWD: begin
        bus.fwd_rdy = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.fwd_data = blk_q;
  assign bus.busy     = (state_q != IDLE);
  assign dbg_state    = state_q;
  assign dbg_bypass   = byp_q;

endmodule

// File: tb/tb_aes_stream_packer.sv
// Bench for aes_stream_packer: a vector table plus hand-written sequences for busy
// load and mid-stream reset, checked against a beat/bundle scoreboard.
module tb_aes_stream_packer;

  localparam int NK     = 8;
  localparam int BW     = 128 * (NK + 1);
  localparam int NBEATS = 2 * (NK + 1);

  logic clk;
  logic rst_n;
  logic [1:0] dbg_state;
  logic       dbg_bypass;

  aes_stream_packer_if #(.NUM_KEYS(NK), .BEAT_W(64)) bus ();

  aes_stream_packer #(.NUM_KEYS(NK), .BEAT_W(64)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .dbg_state  (dbg_state),
    .dbg_bypass (dbg_bypass)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [63:0] exp_q[$];
  logic [BW-1:0] fwd_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int beats_seen = 0;
  int rdy_mode = 0;
  bit tog_en = 1'b0;
  int cyc = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] make_bundle(input logic [127:0] st, input logic [7:0] base);
    logic [BW-1:0] r;
    r[127:0] = st;
    for (int i = 0; i < NK; i++) r[128*(i+1) +: 128] = {16{8'(base + 8'(i))}};
    return r;
  endfunction

  task automatic push_expect(input logic [BW-1:0] bun, input logic byp);
    logic [127:0] blk;
    if (byp) fwd_q.push_back(bun);
    else begin
      for (int b = 0; b < NBEATS; b++) begin
        blk = bun[128*(b/2) +: 128];
        exp_q.push_back(((b % 2) != 0) ? blk[63:0] : blk[127:64]);
      end
    end
  endtask

  // ---------------- monitor ----------------
  logic        stalled = 1'b0;
  logic [63:0] held;

  always @(negedge clk) begin
    if (!rst_n) stalled = 1'b0;
    else begin
      if (bus.busy) check("ld_ready_while_busy", 128'(bus.ld_ready), 128'd0);
      if (bus.prod_valid) begin
        if (stalled) check("stall_hold", 128'(bus.prod_data), 128'(held));
        if (bus.prod_ready) begin
          if (exp_q.size() == 0) check("unexpected_beat", 128'(bus.prod_data), 128'd0 - 128'd1);
          else check($sformatf("beat%0d", beats_seen), 128'(bus.prod_data), 128'(exp_q.pop_front()));
          beats_seen++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held = bus.prod_data;
        end
      end else stalled = 1'b0;
      if (bus.fwd_rdy) begin
        if (fwd_q.size() == 0) check("unexpected_fwd_rdy", 128'(bus.fwd_rdy), 128'd0);
        else begin
          logic [BW-1:0] e;
          e = fwd_q.pop_front();
          for (int s = 0; s <= NK; s++)
            check($sformatf("fwd_slot%0d", s), bus.fwd_data[128*s +: 128], e[128*s +: 128]);
        end
      end
    end
  end

  // ---------------- ready / bypass toggling driver ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      case (rdy_mode)
        0:       bus.prod_ready = 1'b1;
        1:       bus.prod_ready = ((cyc % 3) == 0);
        default: bus.prod_ready = 1'($urandom_range(0, 1));
      endcase
      if (tog_en && bus.busy) bus.bypass_en = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic load(input logic [BW-1:0] bun, input logic byp);
    bit got;
    got = 1'b0;
    @(posedge clk);
    #1;
    bus.ld_state  = bun[127:0];
    bus.ld_keys   = bun[BW-1:128];
    bus.bypass_en = byp;
    bus.ld_valid  = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.ld_ready) begin got = 1'b1; break; end
    end
    check("load_accept", 128'(got), 128'd1);
    @(posedge clk);
    push_expect(bun, byp);
    #1;
    bus.ld_valid = 1'b0;
  endtask

  task automatic wait_idle(input logic byp, input int exp_lat);
    bit done;
    int k;
    done = 1'b0;
    k = 0;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (i == 1) begin
        check("t1_fwd_rdy", 128'(bus.fwd_rdy), 128'(byp));
        check("t1_prod_valid", 128'(bus.prod_valid), 128'(!byp));
      end
      if (!bus.busy && exp_q.size() == 0 && fwd_q.size() == 0) begin
        done = 1'b1;
        k = i;
        break;
      end
    end
    check("done_in_budget", 128'(done), 128'd1);
    if (exp_lat >= 0) check("idle_latency", 128'(k), 128'(exp_lat));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [127:0] st;
    logic [7:0]   key_base;
    logic         byp;
    int           rdy;
    logic         tog;
    int           exp_lat;
  } vec_t;

  vec_t vecs[6];
  localparam logic [127:0] STD_STATE = 128'h00112233445566778899AABBCCDDEEFF;

  initial begin
    logic [BW-1:0] bun, b2;
    int low_cnt;

    vecs[0] = '{STD_STATE, 8'h01, 1'b0, 0, 1'b0, NBEATS + 1};
    vecs[1] = '{STD_STATE, 8'h01, 1'b0, 1, 1'b0, -1};
    vecs[2] = '{STD_STATE, 8'h01, 1'b1, 0, 1'b0, 2};
    vecs[3] = '{{$urandom, $urandom, $urandom, $urandom}, 8'h40, 1'b0, 2, 1'b1, -1};
    vecs[4] = '{{$urandom, $urandom, $urandom, $urandom}, 8'h90, 1'b1, 2, 1'b0, 2};
    vecs[5] = '{{$urandom, $urandom, $urandom, $urandom}, 8'hF8, 1'b0, 0, 1'b1, NBEATS + 1};

    bus.bypass_en  = 1'b0;
    bus.ld_valid   = 1'b0;
    bus.ld_state   = '0;
    bus.ld_keys    = '0;
    bus.prod_ready = 1'b1;
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ld_ready", 128'(bus.ld_ready), 128'd1);
    check("rst_prod_valid", 128'(bus.prod_valid), 128'd0);
    check("rst_prod_data", 128'(bus.prod_data), 128'd0);
    check("rst_fwd_rdy", 128'(bus.fwd_rdy), 128'd0);
    check("rst_busy", 128'(bus.busy), 128'd0);
    for (int s = 0; s <= NK; s++)
      check($sformatf("rst_fwd_slot%0d", s), bus.fwd_data[128*s +: 128], 128'd0);
    rst_n = 1'b1;

    for (int v = 0; v < 6; v++) begin
      rdy_mode = vecs[v].rdy;
      bun = make_bundle(vecs[v].st, vecs[v].key_base);
      load(bun, vecs[v].byp);
      tog_en = vecs[v].tog;
      wait_idle(vecs[v].byp, vecs[v].exp_lat);
      tog_en = 1'b0;
      if (vecs[v].byp) begin
        @(negedge clk);
        check("fwd_hold_slot0", bus.fwd_data[127:0], bun[127:0]);
        check("fwd_hold_slot8", bus.fwd_data[BW-1 -: 128], bun[BW-1 -: 128]);
      end
    end

    // Busy load: second bundle is presented throughout the first stream.
    rdy_mode = 0;
    bun = make_bundle({$urandom, $urandom, $urandom, $urandom}, 8'h10);
    b2  = make_bundle({$urandom, $urandom, $urandom, $urandom}, 8'h20);
    @(posedge clk);
    #1;
    bus.ld_state = bun[127:0];
    bus.ld_keys = bun[BW-1:128];
    bus.bypass_en = 1'b0;
    bus.ld_valid = 1'b1;
    @(posedge clk);
    push_expect(bun, 1'b0);
    #1;
    bus.ld_state = b2[127:0];
    bus.ld_keys = b2[BW-1:128];
    low_cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.ld_ready) break;
      low_cnt++;
    end
    check("busy_drained_before_accept", 128'(exp_q.size()), 128'd0);
    check("busy_ld_ready_low_cycles", 128'(low_cnt), 128'(NBEATS));
    @(posedge clk);
    push_expect(b2, 1'b0);
    #1;
    bus.ld_valid = 1'b0;
    wait_idle(1'b0, NBEATS + 1);

    // Reset in the middle of a stream.
    beats_seen = 0;
    load(make_bundle(STD_STATE, 8'h01), 1'b0);
    for (int i = 0; i < 100 && beats_seen < 7; i++) @(posedge clk);
    check("pre_reset_beats", 128'(beats_seen), 128'd7);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_prod_valid", 128'(bus.prod_valid), 128'd0);
    check("async_busy", 128'(bus.busy), 128'd0);
    check("async_ld_ready", 128'(bus.ld_ready), 128'd1);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_busy", 128'(bus.busy), 128'd0);
    check("post_reset_buf", bus.fwd_data[127:0], 128'd0);
    load(make_bundle({$urandom, $urandom, $urandom, $urandom}, 8'h30), 1'b0);
    wait_idle(1'b0, NBEATS + 1);

    repeat (4) @(negedge clk);
    check("exp_q_empty", 128'(exp_q.size()), 128'd0);
    check("fwd_q_empty", 128'(fwd_q.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
